// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer among NREQ requesters.
// Packets (terminated by a "last" byte) are never interleaved.
//
// Ports:
//   i_clk, i_reset     clock, async active-high reset
//   i_req_valid/last   per-requester handshake valid and end-of-packet flag
//   i_req_data         requester i byte at [i*DBIT +: DBIT]
//   o_req_ready        one-hot accept strobe (combinational, LOAD only)
//   o_tx_start/data    registered start pulse and byte to the serializer
//   i_tx_done_tick     serializer finished the stop bit
//   o_grant            one-hot current owner, zero when idle
//   o_busy             high whenever the FSM is not IDLE
//
// Optional: define TXARB_TIMEOUT_EN to release a stalled packet lock after
// TIMEOUT idle cycles in LOAD.
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*DBIT-1:0] i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_tx_start,
    output logic [DBIT-1:0]      o_tx_data,
    input  logic                 i_tx_done_tick,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_busy
);

    localparam int RW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [RW-1:0]   own_q, own_d;
    logic [NREQ-1:0] grant_d;
    logic            start_d;
    logic [DBIT-1:0] data_d;
    logic            last_q, last_d;

    logic            pick_ok;
    logic [RW-1:0]   pick;
    logic            sel_valid;
    logic            sel_last;
    logic [DBIT-1:0] sel_data;

`ifdef TXARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Rotating search: first valid requester after the last owner.
    always_comb begin
        int j;
        j       = 0;
        pick_ok = 1'b0;
        pick    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!pick_ok && i_req_valid[RW'(j)]) begin
                pick_ok = 1'b1;
                pick    = RW'(j);
            end
        end
    end

    // Owner's handshake signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_q == RW'(i)) begin
                sel_valid = i_req_valid[i];
                sel_last  = i_req_last[i];
                sel_data  = i_req_data[i*DBIT +: DBIT];
            end
        end
    end

    assign o_req_ready = (state_q == LOAD) ? (o_grant & i_req_valid) : '0;
    assign o_busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        grant_d = o_grant;
        start_d = 1'b0;
        data_d  = o_tx_data;
        last_d  = last_q;
`ifdef TXARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    own_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid) begin
                    data_d  = sel_data;
                    start_d = 1'b1;
                    last_d  = sel_last;
                    state_d = WAIT;
                end
`ifdef TXARB_TIMEOUT_EN
                // Owner stalled mid-packet: drop the lock.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rr_d    = own_q;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT: begin
                if (i_tx_done_tick) begin
                    if (last_q) begin
                        rr_d    = own_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rr_q       <= RW'(NREQ - 1);
            own_q      <= '0;
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            last_q     <= 1'b0;
`ifdef TXARB_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            own_q      <= own_d;
            o_grant    <= grant_d;
            o_tx_start <= start_d;
            o_tx_data  <= data_d;
            last_q     <= last_d;
`ifdef TXARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random packet traffic, a stub
// serializer returning done ticks, and a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int DBIT = 8;
`ifdef TXARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 4096;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      r_valid;
    logic [NREQ*DBIT-1:0] r_data;
    logic [NREQ-1:0]      r_last;
    logic [NREQ-1:0]      ready;
    logic                 start;
    logic [DBIT-1:0]      txd;
    logic                 done;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .DBIT(DBIT),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_req_valid(r_valid),
        .i_req_data(r_data),
        .i_req_last(r_last),
        .o_req_ready(ready),
        .o_tx_start(start),
        .o_tx_data(txd),
        .i_tx_done_tick(done),
        .o_grant(grant),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int              total = 0;
    int              bad   = 0;
    logic [DBIT-1:0] exp_q[$];
    logic [8:0]      src_q[NREQ][$];
    int              exp_rdy[NREQ];
    int              got_rdy[NREQ];
    int              m_rr;
    bit              mon_off = 1'b0;
    logic [NREQ-1:0] first_grant;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    // Monitor: every serializer start must carry the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !mon_off && start) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got %0h want none",
                             txd);
                end else begin
                    chk("tx_data", {24'd0, txd}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Serializer stub: done tick a random 0..5 cycles after start.
    initial begin
        int d;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && start) begin
                d = $urandom_range(0, 5);
                repeat (d) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    task automatic add_byte(input int i, input logic [7:0] d,
                            input logic l);
        src_q[i].push_back({l, d});
        exp_rdy[i]++;
    endtask

    // Packet-level round robin: next requester after the last owner that
    // still has a packet sends its whole packet.
    task automatic model_phase();
        logic [8:0] q[NREQ][$];
        logic [8:0] b;
        int         j;
        int         jj;
        bit         found;
        for (int i = 0; i < NREQ; i++) q[i] = src_q[i];
        forever begin
            found = 1'b0;
            j = 0;
            for (int k = 1; k <= NREQ; k++) begin
                jj = (m_rr + k) % NREQ;
                if (!found && q[jj].size() > 0) begin
                    found = 1'b1;
                    j = jj;
                end
            end
            if (!found) break;
            while (q[j].size() > 0) begin
                b = q[j].pop_front();
                exp_q.push_back(b[7:0]);
                if (b[8]) break;
            end
            m_rr = j;
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    // Drives all queued packets; requesters stay valid between packets,
    // and may pause only inside a packet.
    task automatic run_phase(input int budget);
        int  gap[NREQ];
        bit  acc[NREQ];
        int  cyc;
        bit  idle;
        logic l;
        model_phase();
        for (int i = 0; i < NREQ; i++) begin
            gap[i] = 0;
            acc[i] = 1'b0;
            got_rdy[i] = 0;
        end
        first_grant = '0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            idle = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    l = src_q[i][0][8];
                    void'(src_q[i].pop_front());
                    got_rdy[i]++;
                    gap[i] = l ? 0 : $urandom_range(0, 3);
                    acc[i] = 1'b0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (src_q[i].size() > 0) idle = 1'b0;
            end
            if (idle && exp_q.size() == 0 && !busy) break;
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() > 0 && gap[i] == 0) begin
                    r_valid[i] = 1'b1;
                    r_last[i]  = src_q[i][0][8];
                    r_data[i*DBIT +: DBIT] = src_q[i][0][7:0];
                end else begin
                    r_valid[i] = 1'b0;
                    r_last[i]  = 1'b0;
                    r_data[i*DBIT +: DBIT] = '0;
                end
            end
            #1;
            if (first_grant == '0) first_grant = grant;
            for (int i = 0; i < NREQ; i++)
                acc[i] = ready[i] && r_valid[i];
            chk("ready_without_valid", {29'd0, ready & ~r_valid}, 32'd0);
            chk("ready_without_grant", {29'd0, ready & ~grant}, 32'd0);
            chk("ready_onehot", {31'd0, $onehot0(ready)}, 32'd1);
            cyc++;
        end
        chk("phase_budget", {31'd0, cyc < budget}, 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            chk("ready_pulses", got_rdy[i], exp_rdy[i]);
            exp_rdy[i] = 0;
            src_q[i].delete();
        end
        chk("exp_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        r_valid = '0;
    endtask

    initial begin
        int np;
        int len;
        int nst;
        bit ok;
        rst     = 1'b1;
        r_valid = '0;
        r_data  = '0;
        r_last  = '0;
        m_rr    = NREQ - 1;
        for (int i = 0; i < NREQ; i++) exp_rdy[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_ready", {29'd0, ready}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_txd", {24'd0, txd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte 0x41 from requester 0: latency check.
        exp_q.push_back(8'h41);
        r_valid = 3'b001;
        r_data  = 24'h000041;
        r_last  = 3'b001;
        @(posedge clk);
        #1;
        chk("lat_grant", {29'd0, grant}, 32'd1);
        chk("lat_ready", {29'd0, ready}, 32'd1);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_nostart", {31'd0, start}, 32'd0);
        @(posedge clk);
        #1;
        r_valid = '0;
        chk("lat_start", {31'd0, start}, 32'd1);
        chk("lat_txd", {24'd0, txd}, 32'h41);
        chk("wait_ready", {29'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("start_one_cycle", {31'd0, start}, 32'd0);
        wait_idle("first_idle", 50);
        chk("idle_grant", {29'd0, grant}, 32'd0);
        chk("txd_hold", {24'd0, txd}, 32'h41);
        m_rr = 0;

        // Two single-byte packets each from req0 and req1.
        add_byte(0, 8'h10, 1'b1);
        add_byte(0, 8'h10, 1'b1);
        add_byte(1, 8'h20, 1'b1);
        add_byte(1, 8'h20, 1'b1);
        run_phase(2000);

        // 3-byte packet on req1 while req0 waits with 0x55.
        add_byte(1, 8'hA1, 1'b0);
        add_byte(1, 8'hA2, 1'b0);
        add_byte(1, 8'hA3, 1'b1);
        add_byte(0, 8'h55, 1'b1);
        run_phase(2000);

        // All requesters busy: strict rotation.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                add_byte(i, 8'(8'h30 + 8'(r * 4 + i)), 1'b1);
        run_phase(2000);

        // Random packet mixes.
        repeat (8) begin
            for (int i = 0; i < NREQ; i++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        add_byte(i, 8'($urandom), b == len - 1);
                end
            end
            run_phase(5000);
        end

        // Reset in the middle of a packet.
        mon_off = 1'b1;
        r_valid = 3'b010;
        r_data  = 24'h005A00;
        r_last  = 3'b000;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_busy", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        r_valid = '0;
        #1;
        chk("mid_rst_grant", {29'd0, grant}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {29'd0, ready}, 32'd0);
        chk("mid_rst_start", {31'd0, start}, 32'd0);
        chk("mid_rst_txd", {24'd0, txd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nst = 0;
        repeat (10) begin
            @(negedge clk);
            if (start) nst++;
        end
        chk("no_start_after_rst", nst, 32'd0);
        mon_off = 1'b0;
        m_rr = NREQ - 1;
        add_byte(1, 8'h66, 1'b1);
        add_byte(0, 8'h65, 1'b1);
        add_byte(2, 8'h67, 1'b1);
        run_phase(2000);
        chk("first_grant_after_rst", {29'd0, first_grant}, 32'd1);

`ifdef TXARB_TIMEOUT_EN
        // req0 stalls after a non-last byte; req1 is pending.
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        r_valid = 3'b011;
        r_data  = 24'h008877;
        r_last  = 3'b010;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        r_valid[0] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_done", {31'd0, ok}, 32'd1);
        nst = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            nst++;
            if (grant == '0) break;
        end
        chk("to_cycles", nst, TO + 1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_next_grant", {29'd0, grant}, 32'd2);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (ready[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("to_req1_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        r_valid = '0;
        wait_idle("to_idle", 50);
        chk("to_drained", exp_q.size(), 32'd0);
        m_rr = 1;
`endif

        repeat (5) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NREQ requesters (e.g. BIP processor output, debug/monitor unit, loopback echo) using round-robin arbitration.
- Requesters present bytes with a valid/ready handshake. A requester marks the end of a packet with a "last" flag, so multi-byte messages are never interleaved.
- Sits between the requesters and the tx serializer: drives its tx_start/din and consumes its tx_done_tick.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DBIT, 8, byte width presented to the serializer.
- TIMEOUT, 4096, idle cycles allowed mid-packet before the lock is released (used only with TXARB_TIMEOUT_EN).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req_valid  input  NREQ  bit i: requester i has a byte.
- i_req_data  input  NREQ*DBIT  byte of requester i at bits [i*DBIT +: DBIT].
- i_req_last  input  NREQ  bit i: the current byte of requester i ends its packet.
- o_req_ready  output  NREQ  one-hot; bit i high for one cycle when requester i's byte is accepted.
- o_tx_start  output  1  one-cycle pulse to the serializer, registered.
- o_tx_data  output  DBIT  byte for the serializer, registered, stable from the o_tx_start cycle until the next accept.
- i_tx_done_tick  input  1  serializer finished the stop bit.
- o_grant  output  NREQ  one-hot current owner; all zero when none.
- o_busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: state IDLE, o_req_ready=0, o_tx_start=0, o_tx_data=0, o_grant=0, o_busy=0, rr pointer = NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any i_req_valid is set, pick the first set bit searching from rr+1 upward with wrap-around.
  - Register the pick into o_grant and go to LOAD.
- LOAD:
  - o_req_ready[owner] = i_req_valid[owner]. This is combinational, and zero for all other bits.
  - On a transfer (valid & ready):
    - o_tx_data <= i_req_data[owner] and o_tx_start <= 1 at the same edge, so both are seen by the serializer in the next cycle.
    - last_flag <= i_req_last[owner].
    - Go to WAIT.
  - With no valid, stay in LOAD (this is the hold condition).
- WAIT:
  - o_tx_start is high only in the first WAIT cycle.
  - On i_tx_done_tick:
    - If last_flag is set: rr <= owner, o_grant <= 0, go to IDLE.
    - Otherwise go to LOAD with the same owner.
  - i_tx_done_tick outside WAIT is ignored.
- Latency:
  - Valid asserted in cycle 0 from IDLE: o_grant in cycle 1, o_req_ready in cycle 1, o_tx_start in cycle 2.
  - Back-to-back bytes of a packet: the next o_req_ready is in the cycle after done_tick.
- Boundary cases:
  - A requester deasserting valid while it is not granted is legal; it simply loses nothing.
  - Other requesters' valid is ignored while a packet is locked.
  - If every requester is valid, service is strictly 0,1,...,NREQ-1,0 in packet order.
  - A single-byte packet is a byte with last=1.
  - Reset mid-packet: return to reset values immediately. No o_tx_start is emitted after reset deassertion until a new arbitration.
  - o_req_ready is never high in IDLE or WAIT, so a byte is accepted at most once per frame.

Optional Feature:
- Macro: TXARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in LOAD with the owner's valid low. It is cleared on any transfer and on leaving LOAD.
  - When the counter reaches TIMEOUT-1, the lock is released: rr <= owner, o_grant <= 0, go to IDLE.
  - Counter width is $clog2(TIMEOUT).
- Not defined:
  - No counter is built.
  - LOAD waits indefinitely for the owner's next byte.

Test Plan:
- Reset, then req0 valid with data 0x41, last=1 → o_grant=01 in the next cycle, o_tx_start one cycle later with o_tx_data=0x41. After a stubbed done_tick, return to IDLE with o_busy=0.
- req0 and req1 valid simultaneously, each a single byte (0x10, 0x20) repeated → serializer sees 0x10, 0x20, 0x10, 0x20 in strict alternation.
- req1 sends a 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3) while req0 holds valid with 0x55 → 0x55 is sent only after the done_tick of 0xA3. Exactly three o_req_ready[1] pulses occur.
- With the real tx serializer attached (s_tick every 16 cycles), send 0xC3 → line waveform shows start bit, bits 1,1,0,0,0,0,1,1 LSB first, and a stop bit. Exactly one o_tx_start pulse.
- Assert i_reset in the middle of a packet → all outputs are 0 within the same cycle. After release, the first grant goes to requester 0.
- (TXARB_TIMEOUT_EN, TIMEOUT=8) req0 sends a byte with last=0, then drops valid → after 8 cycles in LOAD, o_grant=0 and a pending req1 is granted next.
